// File: rtl/imm_extend_unit_if.sv
// ---------------------------------------------------------------------------
// imm_extend_unit_if : beat-in / result-out handshake bundle for imm_extend_unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imm_extend_unit_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] r;
  logic             hi_pending;
  logic             drop_err;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, r, hi_pending, drop_err, drop_cnt
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, r, hi_pending, drop_err, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/imm_extend_unit.sv
// ---------------------------------------------------------------------------
// imm_extend_unit : zero/sign/left-align extension plus two-beat concatenation
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_extend_unit #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  wire                 clk,
  input  wire                 rst_n,
  imm_extend_unit_if.slave    bus
);

  localparam int HI_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_ZEXT   = 2'b00;
  localparam logic [1:0] MODE_SEXT   = 2'b01;
  localparam logic [1:0] MODE_LALIGN = 2'b10;
  localparam logic [1:0] MODE_CONCAT = 2'b11;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HI_HELD = 1'b1
  } state_t;

  state_t           state;
  logic [HI_W-1:0]  hi;
  logic [OUT_W-1:0] r_q;
  logic             out_valid_q;
  logic             drop_err_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic             in_ready;
  logic             fire;
  logic             is_concat;
  logic             produce;
  logic             drop;
  logic [HI_W-1:0]  hi_cap;
  logic [OUT_W-1:0] ext;

  // The high part comes from the low bits of the first beat, padded if narrow.
  generate
    if (IN_W >= HI_W) begin : g_hi_slice
      assign hi_cap = bus.a[HI_W-1:0];
    end else begin : g_hi_pad
      assign hi_cap = {{(HI_W-IN_W){1'b0}}, bus.a};
    end
  endgenerate

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign fire      = bus.in_valid && in_ready;
  assign is_concat = (bus.mode == MODE_CONCAT);
  assign produce   = fire && !(is_concat && (state == IDLE));
  assign drop      = fire && !is_concat && (state == HI_HELD);

  always_comb begin
    ext = '0;
    case (bus.mode)
      MODE_ZEXT:   ext = {{HI_W{1'b0}}, bus.a};
      MODE_SEXT:   ext = {{HI_W{bus.a[IN_W-1]}}, bus.a};
      MODE_LALIGN: ext = {bus.a, {HI_W{1'b0}}};
      default:     ext = {hi, bus.a};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi          <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      drop_err_q <= drop;
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end

      // A new result wins over a concurrent drain, giving back-to-back throughput.
      if (produce) begin
        r_q         <= ext;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (fire) begin
        case (state)
          IDLE: begin
            if (is_concat) begin
              hi    <= hi_cap;
              state <= HI_HELD;
            end
          end
          HI_HELD: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.r          = r_q;
  assign bus.hi_pending = (state == HI_HELD);
  assign bus.drop_err   = drop_err_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_unit : scoreboard bench for imm_extend_unit (default and CNT_W=2)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imm_extend_unit;

  logic clk;
  logic rst_n;

  imm_extend_unit_if #(.IN_W(12), .OUT_W(16), .CNT_W(8)) bus ();
  imm_extend_unit_if #(.IN_W(12), .OUT_W(16), .CNT_W(2)) bus2 ();

  imm_extend_unit #(.IN_W(12), .OUT_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(16), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // The narrow-counter instance sees exactly the same traffic.
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.a         = bus.a;
  assign bus2.mode      = bus.mode;
  assign bus2.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [15:0] q[$];
  bit          m_ov;
  bit          m_held;
  logic [3:0]  m_hi;
  bit          m_drop;
  int          m_cnt;
  int          m_cnt2;
  bit          last_fire;

  task automatic model_reset();
    q.delete();
    m_ov = 0; m_held = 0; m_hi = '0; m_drop = 0;
    m_cnt = 0; m_cnt2 = 0; last_fire = 0;
  endtask

  // Model evaluated mid-cycle: checks current outputs, predicts the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit          fire;
      bit          nd;
      logic [15:0] res;
      check("in_ready", bus.in_ready, !m_ov || bus.out_ready);
      check("out_valid", bus.out_valid, m_ov);
      check("hi_pending", bus.hi_pending, m_held);
      check("drop_err", bus.drop_err, m_drop);
      check("drop_cnt", bus.drop_cnt, m_cnt);
      check("drop_cnt_w2", bus2.drop_cnt, m_cnt2);
      check("hi_pending_w2", bus2.hi_pending, m_held);
      if (m_ov) begin
        if (q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          check("r", bus.r, q[0]);
          check("r_w2", bus2.r, q[0]);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      fire = bus.in_valid && (!m_ov || bus.out_ready);
      last_fire = fire;
      nd = 0;
      if (fire) begin
        if (bus.mode == 2'b11 && !m_held) begin
          m_held = 1;
          m_hi   = bus.a[3:0];
          m_ov   = m_ov && !bus.out_ready;
        end else begin
          case (bus.mode)
            2'b00:   res = {4'h0, bus.a};
            2'b01:   res = {{4{bus.a[11]}}, bus.a};
            2'b10:   res = {bus.a, 4'h0};
            default: res = {m_hi, bus.a};
          endcase
          if (m_held && bus.mode != 2'b11) begin
            nd = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
          m_held = 0;
          q.push_back(res);
          m_ov = 1;
        end
      end else begin
        m_ov = m_ov && !bus.out_ready;
      end
      m_drop = nd;
    end
  end

  // Called aligned at posedge+1; returns aligned at posedge+1 with in_valid low.
  task automatic send(input logic [1:0] m, input logic [11:0] v);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.a        = v;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (last_fire) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit hold_valid, input logic [11:0] v);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.in_valid = hold_valid;
    bus.mode     = 2'b00;
    bus.a        = v;
    #1;
    check("rst_r", bus.r, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_hi_pending", bus.hi_pending, 0);
    check("rst_drop_err", bus.drop_err, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
    check("rst_drop_cnt_w2", bus2.drop_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.a         = '0;
    bus.out_ready = 1'b1;
    model_reset();

    do_reset(1'b0, 12'h000);

    // Basic extension modes.
    send(2'b00, 12'hABC);
    send(2'b01, 12'h800);
    send(2'b01, 12'h7FF);
    send(2'b10, 12'h123);
    idle(2);

    // Two-beat concatenation.
    send(2'b11, 12'h00D);
    idle(3);
    send(2'b11, 12'h456);
    idle(2);

    // Dropped high part, repeated to saturate the narrow counter.
    send(2'b11, 12'h005);
    send(2'b00, 12'h001);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      send(2'b11, 12'h00A + 12'(i));
      send(2'b01, 12'hF00 + 12'(i));
    end
    idle(2);
    check("cnt_sat_w2", bus2.drop_cnt, 2'd3);
    check("cnt_full", bus.drop_cnt, 8'd5);

    // Backpressure: result held, new beat refused for five cycles.
    bus.out_ready = 1'b0;
    send(2'b10, 12'h0AB);
    bus.in_valid = 1'b1;
    bus.mode     = 2'b00;
    bus.a        = 12'h0CD;
    idle(5);
    check("stall_r", bus.r, 16'h0AB0);
    bus.out_ready = 1'b1;
    send(2'b00, 12'h0CD);

    // Full-throughput stream including a concat pair.
    for (int i = 0; i < 6; i++) send(2'(i % 3), 12'($urandom_range(0, 4095)));
    send(2'b11, 12'h00E);
    send(2'b11, 12'h321);
    send(2'b01, 12'h9A5);
    idle(2);

    // Reset with a stalled result, then reset mid-concatenate.
    bus.out_ready = 1'b0;
    send(2'b00, 12'h777);
    idle(1);
    bus.out_ready = 1'b1;
    do_reset(1'b0, 12'h000);
    send(2'b11, 12'h003);
    do_reset(1'b0, 12'h000);
    send(2'b11, 12'h234);
    idle(4);
    check("after_rst_no_result", bus.out_valid, 0);
    send(2'b11, 12'h001);
    idle(2);

    // Release reset while a beat is already offered.
    do_reset(1'b1, 12'h111);
    idle(3);

    check("sb_left", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter IN_W, default 12, immediate input width; legal range 1..OUT_W-1.
REQ-002 Parameter OUT_W, default 16, datapath/result width.
REQ-003 Parameter CNT_W, default 8, width of the drop counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  immediate beat offered.
REQ-007 in_ready  output  1  unit accepts beat this cycle.
REQ-008 a  input  IN_W  immediate field.
REQ-009 mode  input  2  00 zero-extend, 01 sign-extend, 10 left-align, 11 two-beat concatenate.
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 r  output  OUT_W  extended result.
REQ-013 hi_pending  output  1  first concatenate beat held, waiting for second beat.
REQ-014 drop_err  output  1  one-cycle pulse when a held high part is discarded.
REQ-015 drop_cnt  output  CNT_W  count of discarded high parts, saturating.

Function
REQ-016 Beat accepted ("fire") when in_valid and in_ready are both high on a rising edge.
REQ-017 in_ready = !out_valid || out_ready, combinational; no path from in_valid to in_ready.
REQ-018 Mode 00: r = {(OUT_W-IN_W) zeros, a}.
REQ-019 Mode 01: r = {(OUT_W-IN_W) copies of a[IN_W-1], a}.
REQ-020 Mode 10: r = {a, (OUT_W-IN_W) zeros}.
REQ-021 Modes 00/01/10: result written to r and out_valid set on the fire edge; latency exactly 1 cycle.
REQ-022 Mode 11 uses FSM states IDLE and HI_HELD; no other states.
REQ-023 IDLE + fire with mode 11: capture a[OUT_W-IN_W-1:0] (a zero-extended if IN_W < OUT_W-IN_W) into hi register, go HI_HELD; no result produced, out_valid unchanged except for a concurrent out_ready drain.
REQ-024 HI_HELD + fire with mode 11: r = {hi, a}, out_valid set, go IDLE.
REQ-025 HI_HELD + fire with mode 00/01/10: held hi discarded, beat processed per REQ-018..021, drop_err pulses high the next cycle, drop_cnt increments, go IDLE.
REQ-026 drop_cnt saturates at 2^CNT_W-1; no wrap-around.
REQ-027 hi_pending = 1 exactly when state is HI_HELD.
REQ-028 out_valid cleared on an edge with out_valid && out_ready and no new result written; simultaneous drain and fire with a result yields out_valid = 1 and r = new result (back-to-back, full throughput).
REQ-029 r and out_valid hold stable while out_valid && !out_ready.
REQ-030 in_valid low: no state, r, or counter change except drain per REQ-028.

Reset
REQ-031 rst_n low, at any time including mid-concatenate: state IDLE, hi cleared, out_valid 0, r 0, drop_err 0, drop_cnt 0, hi_pending 0, asynchronously without waiting for clk.
REQ-032 in_ready reads 1 during and after reset (out_valid is 0).
REQ-033 Reset release while in_valid is high: first fire no earlier than first rising edge with rst_n high.

Verification
REQ-034 Defaults; mode 00, a=12'hABC, out_ready=1 -> next cycle r=16'h0ABC, out_valid=1.
REQ-035 Mode 01, a=12'h800 -> r=16'hF800; a=12'h7FF -> r=16'h07FF; mode 10, a=12'h123 -> r=16'h1230.
REQ-036 Mode 11 a=12'h00D then mode 11 a=12'h456 -> hi_pending 1 after first beat, no out_valid; after second r=16'hD456, hi_pending 0.
REQ-037 Mode 11 a=12'h005 then mode 00 a=12'h001 -> r=16'h0001, drop_err pulses once, drop_cnt=1; CNT_W=2 with 5 drops -> drop_cnt=3.
REQ-038 out_ready=0 with out_valid=1 -> in_ready=0, r held for 5 cycles; out_ready=1 with in_valid=1 each cycle -> one result per cycle, no beat lost or duplicated.
REQ-039 rst_n asserted in HI_HELD and with out_valid=1 -> all outputs zero immediately; following mode 11 a=12'h234 yields no result until a second mode 11 beat.
